tb_idle_monitor: RTL
====================

# tb_idle_monitor

Quiescence detector feeding the `idle` input of the simulation-control harness. It tracks outstanding AXI read and write transactions on every DPI-backed memory port and the core's own quiesced flag. It asserts `idle` only after the whole testbench has been verifiably silent for a programmable number of cycles. A sticky error flags protocol accounting faults (response without request, counter overflow) so that the harness never reports a clean finish over a corrupted run.

## Interface
- `NUM_PORTS`, 2: number of monitored AXI ports (≥1).
- `CNT_WIDTH`, 8: width of each per-port outstanding counter; max count 2^CNT_WIDTH−1.
- `QUIET_CYCLES`, 4: consecutive quiet cycles required before `idle` rises (≥1).
- `clock` in 1: sole clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low (0 = reset asserted).
- `ar_fire` in NUM_PORTS: bit p = AR handshake (valid&ready) on port p this cycle.
- `r_last_fire` in NUM_PORTS: bit p = R beat with RLAST handshaked on port p.
- `aw_fire` in NUM_PORTS: bit p = AW handshake on port p.
- `b_fire` in NUM_PORTS: bit p = B handshake on port p.
- `core_quiesced` in 1: core reports no in-flight instructions.
- `idle` out 1: testbench quiescent; drives the harness `idle`.
- `rd_total` out CNT_WIDTH+$clog2(NUM_PORTS)+1: sum of read counters.
- `wr_total` out same width as `rd_total`: sum of write counters.
- `err` out 1: sticky accounting error.
- `err_port` out $clog2(NUM_PORTS) (min 1): port of first error.

## Operation
- Per port p: `rd_cnt[p]` and `wr_cnt[p]`, registered.
- Read counter update: +1 if `ar_fire[p]` only; −1 if `r_last_fire[p]` only; unchanged if both or neither.
- Write counter update: identical rule with `aw_fire`/`b_fire`.
- Underflow (decrement-only at count 0): counter holds 0, error raised.
- Overflow (increment-only at max): counter holds max, error raised.
- Error capture: `err` sets and `err_port` latches the lowest-index faulting port, only on the first error. Both then hold until reset. Later errors do not change `err_port`.
- quiet(t) = all counters zero AND no bit set in any of the four fire vectors AND `core_quiesced` AND !`err`. Evaluated on pre-update counter values.
- FSM states: BUSY, SETTLE, IDLE.
  - BUSY: if quiet, go to SETTLE with `qcnt`=1; if additionally QUIET_CYCLES==1, go straight to IDLE.
  - SETTLE: if !quiet, go to BUSY with `qcnt`=0. Else `qcnt`+1; when `qcnt`+1 == QUIET_CYCLES, go to IDLE.
  - IDLE: if !quiet, go to BUSY.
- `idle` = (state == IDLE), registered.
- `rd_total`/`wr_total` = combinational sums of the registered counters; never truncated.

## Timing
- Reset (`reset`=0 at an edge): all counters 0, `qcnt`=0, state BUSY, `idle`=0, `err`=0, `err_port`=0. `rd_total`=`wr_total`=0 one edge later.
- Reset mid-operation discards all outstanding counts and error state. Fire inputs during reset cycles are ignored.
- Counter latency: a handshake in cycle t is visible on totals after edge t.
- `idle` rises at the edge ending the QUIET_CYCLES-th consecutive quiet cycle. Earliest is QUIET_CYCLES cycles after the last activity.
- `idle` falls at the edge ending the first non-quiet cycle (1-cycle latency). There is no hysteresis beyond the FSM.
- Once `err`=1, `idle` is 0 from the next edge until reset. The harness then times out via its own quit timeout.

## Test plan
- Reset, then hold all inputs 0 with `core_quiesced`=1 and QUIET_CYCLES=4 → `idle`=0 for 3 cycles after reset release and 1 from the 4th edge. Totals 0, `err`=0.
- Port 0: AR at t=10, RLAST at t=15; port 1: AW at t=11, B at t=20; `core_quiesced`=1 → `rd_total`=1 during t11–15 and `wr_total`=1 during t12–20. `idle` rises at the edge ending t=24.
- Simultaneous AR and RLAST on port 1 while `rd_cnt[1]`=3 → stays 3; that cycle is non-quiet, so an IDLE state drops to 0 next edge.
- B on port 1 with `wr_cnt[1]`=0, then B on port 0 with count 0 → `err`=1, `err_port`=1 (unchanged by the second error), `wr_cnt` stays 0. `idle` stays 0 despite quiet inputs.
- CNT_WIDTH=2: 4 AR on port 0 with no R → count saturates at 3, `err`=1 on the 4th, `err_port`=0.
- In IDLE, pulse `core_quiesced`=0 for 1 cycle → `idle` 0 next edge, re-asserts 4 edges after `core_quiesced` returns to 1. Assert `reset`=0 with 2 reads outstanding → totals 0 and `idle`=0 after the edge.

Source files
------------

// File: rtl/tb_idle_monitor.sv
// rtl/tb_idle_monitor.sv - quiescence detector for the sim-control harness idle input
// Tracks outstanding AXI reads/writes per port and raises idle after a run of silent cycles.
module tb_idle_monitor #(
  parameter int NUM_PORTS    = 2,
  parameter int CNT_WIDTH    = 8,
  parameter int QUIET_CYCLES = 4,
  localparam int TW = CNT_WIDTH + $clog2(NUM_PORTS) + 1,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] ar_fire,
  input  logic [NUM_PORTS-1:0] r_last_fire,
  input  logic [NUM_PORTS-1:0] aw_fire,
  input  logic [NUM_PORTS-1:0] b_fire,
  input  logic                 core_quiesced,
  output logic                 idle,
  output logic [TW-1:0]        rd_total,
  output logic [TW-1:0]        wr_total,
  output logic                 err,
  output logic [PW-1:0]        err_port
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {BUSY, SETTLE, IDLE} state_t;

  logic [CNT_WIDTH-1:0] rd_cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] rd_cnt_d [NUM_PORTS];
  logic [CNT_WIDTH-1:0] wr_cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] wr_cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] fault;
  logic                 err_q, err_d;
  logic [PW-1:0]        err_port_q, err_port_d;
  state_t               state_q, state_d;
  logic [QW-1:0]        qcnt_q, qcnt_d;
  logic                 idle_q, idle_d;
  logic                 cnt_zero;
  logic                 quiet;

  // Saturating counters; a fault is an increment at max or a decrement at zero.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    fault    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      case ({ar_fire[p], r_last_fire[p]})
        2'b10: if (rd_cnt_q[p] == CMAX) fault[p] = 1'b1;
               else rd_cnt_d[p] = rd_cnt_q[p] + 1'b1;
        2'b01: if (rd_cnt_q[p] == '0) fault[p] = 1'b1;
               else rd_cnt_d[p] = rd_cnt_q[p] - 1'b1;
        default: ;
      endcase
      case ({aw_fire[p], b_fire[p]})
        2'b10: if (wr_cnt_q[p] == CMAX) fault[p] = 1'b1;
               else wr_cnt_d[p] = wr_cnt_q[p] + 1'b1;
        2'b01: if (wr_cnt_q[p] == '0) fault[p] = 1'b1;
               else wr_cnt_d[p] = wr_cnt_q[p] - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    err_d      = err_q | (|fault);
    err_port_d = err_port_q;
    if (!err_q) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (fault[p]) err_port_d = PW'(p);
      end
    end
  end

  always_comb begin
    cnt_zero = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_cnt_q[p] != '0 || wr_cnt_q[p] != '0) cnt_zero = 1'b0;
    end
    quiet = cnt_zero && !(|{ar_fire, r_last_fire, aw_fire, b_fire})
            && core_quiesced && !err_q;
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      BUSY: if (quiet) begin
        qcnt_d  = QW'(1);
        state_d = (QUIET_CYCLES == 1) ? IDLE : SETTLE;
      end
      SETTLE: if (!quiet) begin
        state_d = BUSY;
        qcnt_d  = '0;
      end else begin
        qcnt_d = qcnt_q + QW'(1);
        if (qcnt_q + QW'(1) == QW'(QUIET_CYCLES)) state_d = IDLE;
      end
      IDLE: if (!quiet) begin
        state_d = BUSY;
        qcnt_d  = '0;
      end
      default: begin
        state_d = BUSY;
        qcnt_d  = '0;
      end
    endcase
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rd_cnt_q[p] <= '0;
        wr_cnt_q[p] <= '0;
      end
      err_q      <= 1'b0;
      err_port_q <= '0;
      state_q    <= BUSY;
      qcnt_q     <= '0;
      idle_q     <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
      err_port_q <= err_port_d;
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      idle_q     <= idle_d;
    end
  end

  always_comb begin
    rd_total = '0;
    wr_total = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_total = rd_total + TW'(rd_cnt_q[p]);
      wr_total = wr_total + TW'(wr_cnt_q[p]);
    end
  end

  assign idle     = idle_q;
  assign err      = err_q;
  assign err_port = err_port_q;

endmodule
